// File: rtl/alarm_ctrl.sv
// Alarm scheduler: holds the alarm as a seconds-of-day count, sequences hour/minute editing
// from key pulses, and drives ring (and, with ALARM_SNOOZE_EN defined, snooze) timing.
module alarm_ctrl #(
    parameter int unsigned DAY_SEC    = 86400,
    parameter int unsigned DEF_ALM    = 25200,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic [19:0] cur_cnt,
    input  logic        key_mode,
    input  logic        key_ok,
    input  logic        key_up,
    output logic [19:0] alm_cnt_o,
    output logic [19:0] disp_cnt_o,
    output logic        alm_en_o,
    output logic        ring_o,
    output logic [2:0]  state_o
);

    localparam int unsigned TMR_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [19:0] DAY_C     = 20'(DAY_SEC);
    localparam logic [19:0] HOUR_C    = 20'd3600;
    localparam logic [19:0] MIN_C     = 20'd60;
    localparam logic [TW-1:0] RING_LAST = TW'(RING_SEC - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_SEC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_HR  = 3'd1,
        S_SET_MIN = 3'd2,
        S_RING    = 3'd3
`ifdef ALARM_SNOOZE_EN
        ,
        S_SNOOZE  = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [19:0]   alm_q, alm_d;
    logic [19:0]   edit_q, edit_d;
    logic [19:0]   disp_q, disp_d;
    logic [19:0]   cur_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          en_q, en_d;
    logic          ring_q, ring_d;

    logic [19:0] hr_sum;
    logic [19:0] min_sum;
    logic        match;

    // A minute step wraps exactly when the sum lands on a whole hour; the seconds
    // field is always zero, so comparing against every hour boundary replaces a modulo.
    function automatic logic on_hour(input logic [19:0] v);
        logic hit;
        // NOTE: blocking '=' is correct inside functions and always_comb; registers use '<='.
        hit = 1'b0;
        for (int k = 1; k * 3600 <= int'(DAY_SEC); k++) begin
            if (v == 20'(k * 3600)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            alm_q   <= 20'(DEF_ALM);
            edit_q  <= 20'(DEF_ALM);
            disp_q  <= 20'(DEF_ALM);
            cur_q   <= '0;
            timer_q <= '0;
            en_q    <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alm_q   <= alm_d;
            edit_q  <= edit_d;
            disp_q  <= disp_d;
            cur_q   <= cur_cnt;
            timer_q <= timer_d;
            en_q    <= en_d;
            ring_q  <= ring_d;
        end
    end

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
        state_d = state_q;
        alm_d   = alm_q;
        edit_d  = edit_q;
        en_d    = en_q;
        timer_d = timer_q;
        hr_sum  = edit_q + HOUR_C;
        min_sum = edit_q + MIN_C;
        match   = en_q && (cur_cnt == alm_q) && (cur_cnt != cur_q);

        case (state_q)
            S_IDLE: begin
                if (match) begin
                    state_d = S_RING;
                    timer_d = '0;
                end else if (key_mode) begin
                    edit_d  = alm_q;
                    state_d = S_SET_HR;
                end else if (key_ok) begin
                    en_d = ~en_q;
                end
            end
            S_SET_HR: begin
                if (key_mode) begin
                    state_d = S_SET_MIN;
                end else if (key_ok) begin
                    alm_d   = edit_q;
                    en_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (key_up) begin
                    edit_d = (hr_sum >= DAY_C) ? hr_sum - DAY_C : hr_sum;
                end
            end
            S_SET_MIN: begin
                if (key_mode) begin
                    state_d = S_IDLE;
                end else if (key_ok) begin
                    alm_d   = edit_q;
                    en_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (key_up) begin
                    edit_d = on_hour(min_sum) ? min_sum - HOUR_C : min_sum;
                end
            end
            S_RING: begin
`ifdef ALARM_SNOOZE_EN
                if (key_mode) begin
                    state_d = S_SNOOZE;
                    timer_d = '0;
                end else
`endif
                if (key_ok) begin
                    state_d = S_IDLE;
                end else if (tick_1hz) begin
                    if (timer_q == RING_LAST) state_d = S_IDLE;
                    else                      timer_d = timer_q + 1'b1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (key_ok) begin
                    state_d = S_IDLE;
                end else if (tick_1hz) begin
                    if (timer_q == SNZ_LAST) begin
                        state_d = S_RING;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        ring_d = (state_d == S_RING);
        disp_d = (state_d == S_SET_HR || state_d == S_SET_MIN) ? edit_d : alm_d;
    end

    assign alm_cnt_o  = alm_q;
    assign disp_cnt_o = disp_q;
    assign alm_en_o   = en_q;
    assign ring_o     = ring_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized traffic, all checked
// against an hour/minute reference model. Define ALARM_SNOOZE_EN to also cover snooze.
module tb_alarm_ctrl;

    localparam int DAY  = 86400;
    localparam int RING = 60;
    localparam int SNZ  = 300;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        km = 1'b0;
    logic        ko = 1'b0;
    logic        ku = 1'b0;
    logic [19:0] cur = 20'd25200;
    logic [19:0] alm_cnt_o;
    logic [19:0] disp_cnt_o;
    logic        alm_en_o;
    logic        ring_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    // Reference model: alarm and edit kept as hour/minute fields, state as plain codes.
    int m_alm_h, m_alm_m, m_edit_h, m_edit_m;
    int m_state, m_timer, m_en, m_cur_q;

    alarm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick),
        .cur_cnt    (cur),
        .key_mode   (km),
        .key_ok     (ko),
        .key_up     (ku),
        .alm_cnt_o  (alm_cnt_o),
        .disp_cnt_o (disp_cnt_o),
        .alm_en_o   (alm_en_o),
        .ring_o     (ring_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_alm_h = 7;  m_alm_m = 0;
        m_edit_h = 7; m_edit_m = 0;
        m_state = 0;  m_timer = 0; m_en = 0; m_cur_q = 0;
    endfunction

    function automatic int m_alm();
        return m_alm_h * 3600 + m_alm_m * 60;
    endfunction

    function automatic int m_disp();
        if (m_state == 1 || m_state == 2) return m_edit_h * 3600 + m_edit_m * 60;
        return m_alm();
    endfunction

    function automatic void model_commit();
        m_alm_h = m_edit_h;
        m_alm_m = m_edit_m;
        m_en    = 1;
        m_state = 0;
    endfunction

    function automatic void model_step(input bit m, input bit o, input bit u, input bit t, input int c);
        bit match;
        match = (m_en != 0) && (c == m_alm()) && (c != m_cur_q);
        case (m_state)
            0: begin
                if (match) begin
                    m_state = 3; m_timer = 0;
                end else if (m) begin
                    m_edit_h = m_alm_h; m_edit_m = m_alm_m; m_state = 1;
                end else if (o) begin
                    m_en = (m_en != 0) ? 0 : 1;
                end
            end
            1: begin
                if (m)      m_state = 2;
                else if (o) model_commit();
                else if (u) m_edit_h = (m_edit_h + 1) % 24;
            end
            2: begin
                if (m)      m_state = 0;
                else if (o) model_commit();
                else if (u) m_edit_m = (m_edit_m + 1) % 60;
            end
            3: begin
                if (SNOOZE_ON && m) begin
                    m_state = 4; m_timer = 0;
                end else if (o) begin
                    m_state = 0;
                end else if (t) begin
                    if (m_timer == RING - 1) m_state = 0;
                    else                     m_timer++;
                end
            end
            4: begin
                if (o) begin
                    m_state = 0;
                end else if (t) begin
                    if (m_timer == SNZ - 1) begin
                        m_state = 3; m_timer = 0;
                    end else begin
                        m_timer++;
                    end
                end
            end
            default: m_state = 0;
        endcase
        m_cur_q = c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/alm"},   32'(alm_cnt_o),  32'(m_alm()));
        check({tag, "/disp"},  32'(disp_cnt_o), 32'(m_disp()));
        check({tag, "/en"},    32'(alm_en_o),   32'(m_en));
        check({tag, "/ring"},  32'(ring_o),     32'(m_state == 3));
        check({tag, "/state"}, 32'(state_o),    32'(m_state));
    endtask

    // Drive one cycle of inputs, advance the model over the same edge, then compare.
    task automatic step(input bit m, input bit o, input bit u, input bit t,
                        input logic [19:0] c, input string tag);
        km = m; ko = o; ku = u; tick = t; cur = c;
        model_step(m, o, u, t, int'(c));
        @(posedge clk);
        #1;
        km = 1'b0; ko = 1'b0; ku = 1'b0; tick = 1'b0;
        compare_all(tag);
    endtask

    logic [19:0] cur_r;
    int          r;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alm",   32'(alm_cnt_o),  32'd25200);
        check("rst_disp",  32'(disp_cnt_o), 32'd25200);
        check("rst_en",    32'(alm_en_o),   32'd0);
        check("rst_ring",  32'(ring_o),     32'd0);
        check("rst_state", 32'(state_o),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: disarmed alarm held at its own time never rings.
        repeat (4) step(0, 0, 0, 1, 20'd25200, "t1_hold");
        check("t1_ring", 32'(ring_o), 32'd0);

        // Test 2: hour 7+17 wraps to 0, minute 0+61 wraps to 1 -> 60 s.
        step(1, 0, 0, 0, 20'd100, "t2_mode");
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 20'd100, "t2_hr");
        check("t2_disp_hr", 32'(disp_cnt_o), 32'd0);
        step(1, 0, 0, 0, 20'd100, "t2_mode2");
        for (int i = 0; i < 61; i++) step(0, 0, 1, 0, 20'd100, "t2_min");
        step(0, 1, 0, 0, 20'd100, "t2_ok");
        check("t2_alm", 32'(alm_cnt_o), 32'd60);
        check("t2_en",  32'(alm_en_o),  32'd1);

        // Test 3: 59 -> 60 rings one cycle later; 60 ticks stop it.
        step(0, 0, 0, 0, 20'd59, "t3_pre");
        step(0, 0, 0, 0, 20'd60, "t3_match");
        check("t3_ring_on", 32'(ring_o), 32'd1);
        for (int i = 0; i < RING - 1; i++) step(0, 0, 0, 1, 20'd60, "t3_tick");
        check("t3_ring_59", 32'(ring_o), 32'd1);
        step(0, 0, 0, 1, 20'd60, "t3_last");
        check("t3_ring_off", 32'(ring_o),  32'd0);
        check("t3_idle",     32'(state_o), 32'd0);
        check("t3_en_kept",  32'(alm_en_o), 32'd1);

        // Test 4: key_ok coincident with a tick stops the ring; held time does not re-ring.
        step(0, 0, 0, 0, 20'd59, "t4_pre");
        step(0, 0, 0, 0, 20'd60, "t4_match");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 20'd60, "t4_tick");
        step(0, 1, 0, 1, 20'd60, "t4_ok");
        check("t4_idle", 32'(state_o), 32'd0);
        repeat (3) step(0, 0, 0, 1, 20'd60, "t4_hold");
        check("t4_noring", 32'(ring_o), 32'd0);

        // Test 5: a match during editing is dropped; key_mode in SET_MIN discards the edit.
        step(0, 0, 0, 0, 20'd59, "t5_pre");
        step(1, 0, 0, 0, 20'd59, "t5_sethr");
        step(1, 0, 0, 0, 20'd59, "t5_setmin");
        step(0, 0, 0, 0, 20'd60, "t5_match");
        check("t5_state", 32'(state_o), 32'd2);
        check("t5_ring",  32'(ring_o),  32'd0);
        repeat (3) step(0, 0, 1, 0, 20'd60, "t5_up");
        step(1, 0, 0, 0, 20'd60, "t5_discard");
        check("t5_alm", 32'(alm_cnt_o), 32'd60);
        step(0, 0, 0, 0, 20'd60, "t5_hold");
        check("t5_noring", 32'(ring_o), 32'd0);

        // Test 6: snooze (when built in), then asynchronous reset mid-ring.
        step(0, 0, 0, 0, 20'd59, "t6_pre");
        step(0, 0, 0, 0, 20'd60, "t6_match");
        step(1, 0, 0, 0, 20'd60, "t6_mode");
`ifdef ALARM_SNOOZE_EN
        check("t6_snz_state", 32'(state_o), 32'd4);
        check("t6_snz_ring",  32'(ring_o),  32'd0);
        for (int i = 0; i < SNZ - 1; i++) step(0, 0, 0, 1, 20'd60, "t6_snz");
        check("t6_snz_299", 32'(state_o), 32'd4);
        step(0, 0, 0, 1, 20'd60, "t6_snz_end");
        check("t6_rering_state", 32'(state_o), 32'd3);
        check("t6_rering_ring",  32'(ring_o),  32'd1);
`else
        check("t6_mode_ignored", 32'(state_o), 32'd3);
`endif
        repeat (3) step(0, 0, 0, 1, 20'd60, "t6_ring");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_arst_alm",   32'(alm_cnt_o),  32'd25200);
        check("t6_arst_disp",  32'(disp_cnt_o), 32'd25200);
        check("t6_arst_en",    32'(alm_en_o),   32'd0);
        check("t6_arst_ring",  32'(ring_o),     32'd0);
        check("t6_arst_state", 32'(state_o),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic biased toward hitting the alarm time.
        cur_r = 20'd0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 3 || r == 4)      cur_r = 20'(m_alm());
            else if (r == 5)           cur_r = 20'((m_alm() == 0) ? DAY - 1 : m_alm() - 1);
            else if (r >= 6)           cur_r = 20'($urandom_range(0, DAY - 1));
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 5) == 0),  ($urandom_range(0, 1) == 0),
                 cur_r, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
